// File: rtl/vec_pkg.sv
// Shared types and sizes for the vector load/store unit.
package vec_pkg;
  localparam int N     = 20;
  localparam int LANES = 8;

  typedef logic [LANES-1:0][N-1:0] vec_t;
  typedef logic [2:0]              lane_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_R,
    DONE
  } state_t;
endpackage

// File: rtl/vmem_addr_gen.sv
// Per-lane word address generator for vec_mem_access.
// VMEM_GATHER_EN defined: gather/scatter per-lane addresses; undefined: unit stride from lane 0.
module vmem_addr_gen #(
  parameter int N = vec_pkg::N
) (
`ifdef VMEM_GATHER_EN
  input  logic [(2**$bits(vec_pkg::lane_t))-1:0][N-1:0] addr_src,
`else
  input  logic [N-1:0]                                  addr_src,
`endif
  input  vec_pkg::lane_t                                lane,
  output logic [N-1:0]                                  addr
);

`ifdef VMEM_GATHER_EN
  assign addr = addr_src[lane];
`else
  // Natural N-bit wrap gives the modulo 2^N stride behaviour.
  assign addr = addr_src + N'(lane);
`endif

endmodule

// File: rtl/vec_mem_access.sv
// Sequential vector load/store engine: one memory word per lane, lanes 0..7, one request in flight.
// VMEM_GATHER_EN selects gather/scatter addressing instead of unit stride.
module vec_mem_access #(
  parameter int N     = vec_pkg::N,
  parameter int LANES = vec_pkg::LANES
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      MemReadM,
  input  logic                      MemWriteM,
  input  logic [LANES-1:0][N-1:0]   AluResultM,
  input  logic [LANES-1:0][N-1:0]   WriteDataM,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [N-1:0]              mem_addr,
  output logic [N-1:0]              mem_wdata,
  input  logic                      mem_gnt,
  input  logic                      mem_rvalid,
  input  logic [N-1:0]              mem_rdata,
  output logic [LANES-1:0][N-1:0]   ReadDataM,
  output logic                      StallM,
  output logic                      DoneM
);
  import vec_pkg::*;

  localparam lane_t LAST_LANE = lane_t'(LANES - 1);

  state_t                  state, state_nxt;
  lane_t                   lane;
  logic                    is_store;
  logic                    start;
  logic                    last;
  logic [LANES-1:0][N-1:0] cap_data;
  logic [N-1:0]            lane_addr;

`ifdef VMEM_GATHER_EN
  logic [LANES-1:0][N-1:0] cap_addr;
`else
  logic [N-1:0]            cap_addr;
  logic                    unused_alu_hi;
  assign unused_alu_hi = ^AluResultM[LANES-1:1];
`endif

  assign start = (state == IDLE) && (MemReadM || MemWriteM);
  assign last  = (lane == LAST_LANE);

  vmem_addr_gen #(.N(N)) u_addr_gen (
    .addr_src (cap_addr),
    .lane     (lane),
    .addr     (lane_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    StallM    = 1'b0;
    DoneM     = 1'b0;
    case (state)
      IDLE: begin
        // Stall in the accept cycle so EX/MEM holds while the operands are captured.
        StallM = rst_n && (MemReadM || MemWriteM);
        if (start) state_nxt = REQ;
      end
      REQ: begin
        mem_req   = 1'b1;
        mem_we    = is_store;
        mem_addr  = lane_addr;
        mem_wdata = cap_data[lane];
        StallM    = 1'b1;
        if (mem_gnt) begin
          if (!is_store)  state_nxt = WAIT_R;
          else if (last)  state_nxt = DONE;
        end
      end
      WAIT_R: begin
        StallM = 1'b1;
        if (mem_rvalid) state_nxt = last ? DONE : REQ;
      end
      DONE: begin
        DoneM     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane      <= '0;
      is_store  <= 1'b0;
      cap_addr  <= '0;
      cap_data  <= '0;
      ReadDataM <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            // A simultaneous read and write resolves to a store.
            is_store <= MemWriteM;
            lane     <= '0;
            cap_data <= WriteDataM;
`ifdef VMEM_GATHER_EN
            cap_addr <= AluResultM;
`else
            cap_addr <= AluResultM[0];
`endif
          end
        end
        REQ: begin
          if (mem_gnt && is_store && !last) lane <= lane + 3'd1;
        end
        WAIT_R: begin
          if (mem_rvalid) begin
            ReadDataM[lane] <= mem_rdata;
            if (!last) lane <= lane + 3'd1;
          end
        end
        DONE:    lane <= '0;
        default: lane <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_mem_access.sv
// Scoreboard bench for vec_mem_access: expected memory transactions are queued by the stimulus
// and popped by a monitor on every granted request. Define VMEM_GATHER_EN to add the gather case.
module tb_vec_mem_access;
  import vec_pkg::*;

  typedef struct {
    logic         we;
    logic [N-1:0] addr;
    logic [N-1:0] wdata;
  } txn_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         MemReadM = 1'b0;
  logic         MemWriteM = 1'b0;
  vec_t         AluResultM = '0;
  vec_t         WriteDataM = '0;
  vec_t         ReadDataM;
  logic         mem_req, mem_we;
  logic [N-1:0] mem_addr, mem_wdata;
  logic         mem_gnt = 1'b0;
  logic         mem_rvalid = 1'b0;
  logic [N-1:0] mem_rdata = '0;
  logic         StallM, DoneM;

  txn_t         exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           stall_cnt = 0;
  int           done_cnt = 0;
  int           grant_cnt = 0;
  int           rd_idx = 0;
  int           hold_left = 0;
  logic         hold_en = 1'b0;
  logic [N-1:0] hold_addr = '0;
  logic [N-1:0] hold_wdata = '0;
  logic         rv_pending = 1'b0;

  always #5 clk = ~clk;

  vec_mem_access dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .AluResultM (AluResultM),
    .WriteDataM (WriteDataM),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .DoneM      (DoneM)
  );

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic pushTxn(input logic we, input logic [N-1:0] addr, input logic [N-1:0] wdata);
    txn_t t;
    t.we    = we;
    t.addr  = addr;
    t.wdata = wdata;
    exp_q.push_back(t);
  endtask

  // Monitor: counts stall/done cycles and checks each granted request against the queue.
  always @(negedge clk) begin
    txn_t t;
    if (rst_n) begin
      if (StallM) stall_cnt++;
      if (DoneM)  done_cnt++;
      if (mem_req && mem_gnt) begin
        grant_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_txn got addr 0x%0h we %0b, none expected", mem_addr, mem_we);
        end else begin
          t = exp_q.pop_front();
          checkOutput("txn_we", 32'(mem_we), 32'(t.we));
          checkOutput("txn_addr", 32'(mem_addr), 32'(t.addr));
          if (t.we) checkOutput("txn_wdata", 32'(mem_wdata), 32'(t.wdata));
        end
      end
    end
    rv_pending = rst_n && mem_req && mem_gnt && !mem_we;
  end

  // Memory model: grant (optionally withheld on one address) and read data one cycle after grant.
  always @(posedge clk) begin
    #1;
    mem_rvalid = rv_pending;
    mem_rdata  = rv_pending ? (20'h05000 + N'(rd_idx)) : '0;
    if (rv_pending) rd_idx++;
    if (hold_en && mem_req && (mem_addr == hold_addr) && hold_left > 0) begin
      mem_gnt = 1'b0;
      hold_left--;
      checkOutput("hold_req", 32'(mem_req), 32'd1);
      checkOutput("hold_addr", 32'(mem_addr), 32'(hold_addr));
      checkOutput("hold_wdata", 32'(mem_wdata), 32'(hold_wdata));
    end else begin
      mem_gnt = 1'b1;
    end
  end

  function automatic vec_t strideAddr(input logic [N-1:0] base);
    vec_t v;
    for (int i = 0; i < LANES; i++) begin
`ifdef VMEM_GATHER_EN
      v[i] = base + N'(i);
`else
      v[i] = (i == 0) ? base : (20'hDEAD0 + N'(i));
`endif
    end
    return v;
  endfunction

  function automatic vec_t dataVec(input logic [N-1:0] base);
    vec_t v;
    for (int i = 0; i < LANES; i++) v[i] = base + N'(i);
    return v;
  endfunction

  task automatic applyStimulus(input logic rd, input logic wr, input vec_t addr, input vec_t data);
    @(posedge clk);
    #1;
    stall_cnt  = 0;
    done_cnt   = 0;
    MemReadM   = rd;
    MemWriteM  = wr;
    AluResultM = addr;
    WriteDataM = data;
    @(posedge clk);
    #1;
    MemReadM  = 1'b0;
    MemWriteM = 1'b0;
  endtask

  task automatic waitDone(input string name, input int exp_stall);
    int n;
    n = 0;
    while (!DoneM && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (!DoneM) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout got no DoneM expected DoneM within 80 cycles", name);
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput({name, "_stall"}, 32'(stall_cnt), 32'(exp_stall));
    checkOutput({name, "_done"}, 32'(done_cnt), 32'd1);
  endtask

  initial begin
    logic [N-1:0] load_addr[8];
    logic [N-1:0] gather_addr[8];
    vec_t         v;
    int           n;
    load_addr   = '{20'hFFFFE, 20'hFFFFF, 20'h00000, 20'h00001,
                    20'h00002, 20'h00003, 20'h00004, 20'h00005};
    gather_addr = '{20'd7, 20'd3, 20'd9, 20'd0, 20'd1, 20'd2, 20'd8, 20'd5};

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_req", 32'(mem_req), 32'd0);
    checkOutput("rst_stall", 32'(StallM), 32'd0);
    checkOutput("rst_done", 32'(DoneM), 32'd0);
    checkOutput("rst_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_rdata0", 32'(ReadDataM[0]), 32'd0);
    rst_n = 1'b1;

    $display("[TB] unit-stride store");
    for (int i = 0; i < 8; i++) pushTxn(1'b1, 20'h00100 + N'(i), 20'h0000A + N'(i));
    applyStimulus(1'b0, 1'b1, strideAddr(20'h00100), dataVec(20'h0000A));
    waitDone("store", 9);

    $display("[TB] wrapping load");
    rd_idx = 0;
    for (int i = 0; i < 8; i++) pushTxn(1'b0, load_addr[i], '0);
    applyStimulus(1'b1, 1'b0, strideAddr(20'hFFFFE), '0);
    waitDone("load", 17);
    for (int i = 0; i < 8; i++) checkOutput("load_data", 32'(ReadDataM[i]), 32'h5000 + 32'(i));

    $display("[TB] grant withheld on lane 2");
    hold_addr  = 20'h00202;
    hold_wdata = 20'h00032;
    hold_left  = 3;
    hold_en    = 1'b1;
    for (int i = 0; i < 8; i++) pushTxn(1'b1, 20'h00200 + N'(i), 20'h00030 + N'(i));
    applyStimulus(1'b0, 1'b1, strideAddr(20'h00200), dataVec(20'h00030));
    waitDone("hold", 12);
    checkOutput("hold_applied", 32'(hold_left), 32'd0);
    hold_en = 1'b0;

    $display("[TB] read and write together");
    for (int i = 0; i < 8; i++) pushTxn(1'b1, 20'h00300 + N'(i), 20'h00040 + N'(i));
    applyStimulus(1'b1, 1'b1, strideAddr(20'h00300), dataVec(20'h00040));
    waitDone("both", 9);
    for (int i = 0; i < 8; i++) checkOutput("both_keep_data", 32'(ReadDataM[i]), 32'h5000 + 32'(i));

    $display("[TB] reset in WAIT_R lane 4");
    rd_idx    = 0;
    grant_cnt = 0;
    for (int i = 0; i < 5; i++) pushTxn(1'b0, 20'h00400 + N'(i), '0);
    applyStimulus(1'b1, 1'b0, strideAddr(20'h00400), '0);
    n = 0;
    while (grant_cnt < 5 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rst_mid_grants", 32'(grant_cnt), 32'd5);
    @(posedge clk);
    #2;
    checkOutput("wait_r_stall", 32'(StallM), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_req", 32'(mem_req), 32'd0);
    checkOutput("rst_mid_we", 32'(mem_we), 32'd0);
    checkOutput("rst_mid_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_mid_wdata", 32'(mem_wdata), 32'd0);
    checkOutput("rst_mid_stall", 32'(StallM), 32'd0);
    checkOutput("rst_mid_done", 32'(DoneM), 32'd0);
    for (int i = 0; i < 8; i++) checkOutput("rst_mid_rdata", 32'(ReadDataM[i]), 32'd0);
    checkOutput("rst_mid_queue", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) pushTxn(1'b1, 20'h00500 + N'(i), 20'h00060 + N'(i));
    applyStimulus(1'b0, 1'b1, strideAddr(20'h00500), dataVec(20'h00060));
    waitDone("restart", 9);

`ifdef VMEM_GATHER_EN
    $display("[TB] gather store");
    for (int i = 0; i < 8; i++) begin
      v[i] = gather_addr[i];
      pushTxn(1'b1, gather_addr[i], 20'h00070 + N'(i));
    end
    applyStimulus(1'b0, 1'b1, v, dataVec(20'h00070));
    waitDone("gather", 9);
`else
    v = '0;
`endif

    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
